cram_arbiter: RTL and testbench

Sequencing controller and arbiter for the 512x8 asynchronous color RAM. It shares the RAM between three requesters in fixed priority: video palette fetch, then CPU read/write, then a built-in fill engine that clears or sets the RAM. It owns the SRAM control pins (chip enable, output enable, write enable, address, split data bus) and generates the setup, pulse and hold timing the 45 ns part needs.

---
 rtl/cram_arb_pkg.sv | 10 +
 rtl/cram_fill_ctr.sv | 50 +++++
 rtl/cram_arbiter.sv | 136 +++++++++++++
 tb/tb_cram_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cram_arb_pkg.sv
// cram_arb_pkg: shared types and default sizing for the color RAM arbiter
// Holds the sequencer state enum, the requester id enum and default parameters.
package cram_arb_pkg;
    typedef enum logic [2:0] {IDLE, RD, WS, WP, WH, GAP} state_e;
    typedef enum logic [1:0] {SRC_VID, SRC_CPU, SRC_FILL} src_e;
    localparam int CRAM_ADDR_W   = 9;
    localparam int CRAM_DATA_W   = 8;
    localparam int CRAM_RD_WAIT  = 2;
    localparam int CRAM_WR_PULSE = 1;
endpackage

// File: rtl/cram_fill_ctr.sv
// cram_fill_ctr: fill address counter, latched fill value and busy flag
// Ports: clk_i/rst_i clock and async reset; start_i/data_i start pulse and fill value;
//        inc_i advance after a completed fill write; stop_i clear busy (last write done);
//        addr_o/data_o current fill address and value; busy_o fill pending; last_o at top address.
module cram_fill_ctr
    import cram_arb_pkg::*;
#(
    parameter int ADDR_W = CRAM_ADDR_W,
    parameter int DATA_W = CRAM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              inc_i,
    input  logic              stop_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d, go;

    // a start pulse arriving while a fill is running is dropped
    always_comb begin
        go     = start_i && !busy_q;
        addr_d = go ? '0 : inc_i ? addr_q + 1'b1 : addr_q;
        data_d = go ? data_i : data_q;
        busy_d = go || (busy_q && !stop_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign addr_o = addr_q;
    assign data_o = data_q;
    assign busy_o = busy_q;
    assign last_o = &addr_q;
endmodule

// File: rtl/cram_arbiter.sv
// cram_arbiter: fixed-priority sequencer sharing an async color RAM between video, CPU and fill
// Ports: CLK/RST clock and async reset; VID_* video read port; CPU_* CPU read/write port;
//        FILL_* fill engine control; SRAM_* RAM pins (active-low controls, split data bus).
module cram_arbiter
    import cram_arb_pkg::*;
#(
    parameter int ADDR_W   = CRAM_ADDR_W,
    parameter int DATA_W   = CRAM_DATA_W,
    parameter int RD_WAIT  = CRAM_RD_WAIT,
    parameter int WR_PULSE = CRAM_WR_PULSE
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_ADDR,
    output logic              VID_ACK,
    output logic [DATA_W-1:0] VID_DATA,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_ACK,
    output logic [DATA_W-1:0] CPU_RDATA,
    input  logic              FILL_START,
    input  logic [DATA_W-1:0] FILL_DATA,
    output logic              FILL_BUSY,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CEn,
    output logic              SRAM_OEn,
    output logic              SRAM_WEn,
    output logic [DATA_W-1:0] SRAM_DOUT,
    output logic              SRAM_DOE,
    input  logic [DATA_W-1:0] SRAM_DIN
);
    state_e            state_q;
    src_e              src_q, g_src;
    logic [7:0]        cnt_q;
    logic              fill_last, fill_inc, fill_done, g_vid, g_cpu, g_fill, g_we;
    logic [ADDR_W-1:0] fill_addr, g_addr;
    logic [DATA_W-1:0] fill_data, g_data;

    cram_fill_ctr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fill (
        .clk_i  (CLK),
        .rst_i  (RST),
        .start_i(FILL_START),
        .data_i (FILL_DATA),
        .inc_i  (fill_inc),
        .stop_i (fill_done),
        .addr_o (fill_addr),
        .data_o (fill_data),
        .busy_o (FILL_BUSY),
        .last_o (fill_last)
    );

    // a fill write completes on the WH -> GAP edge
    assign fill_inc  = state_q == WH && src_q == SRC_FILL;
    assign fill_done = fill_inc && fill_last;

    always_comb begin
        g_vid  = VID_REQ;
        g_cpu  = !VID_REQ && CPU_REQ;
        g_fill = !VID_REQ && !CPU_REQ && FILL_BUSY;
        g_src  = g_vid ? SRC_VID : g_cpu ? SRC_CPU : SRC_FILL;
        g_addr = g_vid ? VID_ADDR : g_cpu ? CPU_ADDR : fill_addr;
        g_data = g_cpu ? CPU_WDATA : fill_data;
        g_we   = g_cpu ? CPU_WE : g_fill;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            src_q     <= SRC_VID;
            cnt_q     <= '0;
            SRAM_ADDR <= '0;
            SRAM_DOUT <= '0;
            SRAM_CEn  <= 1'b1;
            SRAM_OEn  <= 1'b1;
            SRAM_WEn  <= 1'b1;
            SRAM_DOE  <= 1'b0;
            VID_ACK   <= 1'b0;
            CPU_ACK   <= 1'b0;
            VID_DATA  <= '0;
            CPU_RDATA <= '0;
        end else begin
            VID_ACK <= 1'b0;
            CPU_ACK <= 1'b0;
            case (state_q)
                IDLE, GAP: begin
                    if (g_vid || g_cpu || g_fill) begin
                        state_q   <= g_we ? WS : RD;
                        src_q     <= g_src;
                        cnt_q     <= 8'(RD_WAIT - 1);
                        SRAM_ADDR <= g_addr;
                        SRAM_CEn  <= 1'b0;
                        SRAM_OEn  <= g_we;
                        SRAM_DOE  <= g_we;
                        if (g_we) SRAM_DOUT <= g_data;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == '0) begin
                        state_q  <= GAP;
                        SRAM_CEn <= 1'b1;
                        SRAM_OEn <= 1'b1;
                        VID_ACK  <= src_q == SRC_VID;
                        CPU_ACK  <= src_q == SRC_CPU;
                        if (src_q == SRC_VID) VID_DATA <= SRAM_DIN;
                        else CPU_RDATA <= SRAM_DIN;
                    end
                end
                WS: begin
                    state_q  <= WP;
                    SRAM_WEn <= 1'b0;
                    cnt_q    <= 8'(WR_PULSE - 1);
                end
                WP: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == '0) begin
                        state_q  <= WH;
                        SRAM_WEn <= 1'b1;
                    end
                end
                WH: begin
                    state_q  <= GAP;
                    SRAM_CEn <= 1'b1;
                    SRAM_DOE <= 1'b0;
                    CPU_ACK  <= src_q == SRC_CPU;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cram_arbiter.sv
// tb_cram_arbiter: scoreboard bench for cram_arbiter with a behavioural 512x8 RAM
module tb_cram_arbiter;
    logic       CLK = 1'b0, RST = 1'b1;
    logic       VID_REQ = 1'b0, CPU_REQ = 1'b0, CPU_WE = 1'b0, FILL_START = 1'b0;
    logic [8:0] VID_ADDR = '0, CPU_ADDR = '0;
    logic [7:0] CPU_WDATA = '0, FILL_DATA = '0;
    logic       VID_ACK, CPU_ACK, FILL_BUSY, SRAM_CEn, SRAM_OEn, SRAM_WEn, SRAM_DOE;
    logic [7:0] VID_DATA, CPU_RDATA, SRAM_DOUT, SRAM_DIN, bus_wr;
    logic [8:0] SRAM_ADDR;

    typedef struct {
        bit         vid;
        logic [7:0] data;
        bit         chk_data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_cmp = 0, n_bad = 0, cyc = 0;
    logic [7:0] mem [512];

    cram_arbiter dut (
        .CLK(CLK), .RST(RST),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_ACK(VID_ACK), .VID_DATA(VID_DATA),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
        .FILL_START(FILL_START), .FILL_DATA(FILL_DATA), .FILL_BUSY(FILL_BUSY),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_CEn(SRAM_CEn), .SRAM_OEn(SRAM_OEn), .SRAM_WEn(SRAM_WEn),
        .SRAM_DOUT(SRAM_DOUT), .SRAM_DOE(SRAM_DOE), .SRAM_DIN(SRAM_DIN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    assign bus_wr   = SRAM_DOE ? SRAM_DOUT : 8'h00;
    assign SRAM_DIN = (!SRAM_CEn && !SRAM_OEn) ? mem[SRAM_ADDR] : 8'h00;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
        forever begin
            @(posedge CLK);
            if (!SRAM_CEn && !SRAM_WEn && SRAM_DOE) mem[SRAM_ADDR] = bus_wr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ack(input bit vid, input logic [7:0] d, input bit cd, input int c);
        exp_t e;
        e.vid = vid;
        e.data = d;
        e.chk_data = cd;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic cpu_op(input bit we, input logic [8:0] a, input logic [7:0] wd,
                          input logic [7:0] ed, input int lat);
        CPU_REQ = 1'b1;
        CPU_WE = we;
        CPU_ADDR = a;
        CPU_WDATA = wd;
        expect_ack(1'b0, ed, !we, lat < 0 ? -1 : cyc + 1 + lat);
        for (int t = 0; t < 40; t++) begin
            @(negedge CLK);
            if (CPU_ACK) break;
        end
        chk("cpu_ack_seen", CPU_ACK, 1);
        CPU_REQ = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RST && (VID_ACK || CPU_ACK)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {VID_ACK, CPU_ACK}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_src_vid", VID_ACK, mon_e.vid);
                chk("ack_src_cpu", CPU_ACK, !mon_e.vid);
                if (mon_e.cyc >= 0) chk("ack_cycle", cyc, mon_e.cyc);
                if (mon_e.chk_data) chk("ack_data", mon_e.vid ? VID_DATA : CPU_RDATA, mon_e.data);
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST)
            chk("pin_protocol", (!SRAM_OEn && SRAM_DOE) || (!SRAM_WEn && (SRAM_CEn || !SRAM_DOE || !SRAM_OEn)), 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int g, k, n, lat, t_req;
        repeat (3) @(negedge CLK);
        chk("rst_cen", SRAM_CEn, 1);
        chk("rst_oen", SRAM_OEn, 1);
        chk("rst_wen", SRAM_WEn, 1);
        chk("rst_doe", SRAM_DOE, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_dout", SRAM_DOUT, 0);
        chk("rst_acks", {VID_ACK, CPU_ACK}, 0);
        chk("rst_vdata", VID_DATA, 0);
        chk("rst_cdata", CPU_RDATA, 0);
        chk("rst_busy", FILL_BUSY, 0);
        RST = 1'b0;
        @(negedge CLK);
        FILL_START = 1'b1;
        FILL_DATA = 8'hFF;
        CPU_REQ = 1'b1;
        CPU_WE = 1'b1;
        CPU_ADDR = 9'h055;
        CPU_WDATA = 8'h77;
        @(negedge CLK);
        FILL_START = 1'b0;
        CPU_REQ = 1'b0;
        chk("midwp_busy_set", FILL_BUSY, 1);
        chk("midwp_ws_wen", SRAM_WEn, 1);
        @(negedge CLK);
        chk("midwp_wp_wen", SRAM_WEn, 0);
        RST = 1'b1;
        #1;
        chk("midwp_rst_wen", SRAM_WEn, 1);
        chk("midwp_rst_cen", SRAM_CEn, 1);
        chk("midwp_rst_doe", SRAM_DOE, 0);
        chk("midwp_rst_busy", FILL_BUSY, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            chk("midwp_no_ack", CPU_ACK, 0);
            chk("midwp_fill_cancel", FILL_BUSY, 0);
        end
        cpu_op(1'b0, 9'h055, 8'h00, 8'h0F, 2);
        @(negedge CLK);
        VID_REQ = 1'b1;
        VID_ADDR = 9'h010;
        CPU_REQ = 1'b1;
        CPU_WE = 1'b0;
        CPU_ADDR = 9'h020;
        g = cyc + 1;
        expect_ack(1'b1, 8'h4A, 1'b1, g + 2);
        expect_ack(1'b0, 8'h7A, 1'b1, g + 5);
        for (int t = 0; t < 40 && CPU_REQ; t++) begin
            @(negedge CLK);
            if (VID_ACK) VID_REQ = 1'b0;
            if (CPU_ACK) CPU_REQ = 1'b0;
        end
        chk("prio_cpu_done", CPU_REQ, 0);
        @(negedge CLK);
        VID_REQ = 1'b1;
        VID_ADDR = 9'h030;
        g = cyc + 1;
        expect_ack(1'b1, 8'h6A, 1'b1, g + 2);
        expect_ack(1'b1, 8'h6B, 1'b1, g + 5);
        expect_ack(1'b1, 8'h68, 1'b1, g + 8);
        expect_ack(1'b1, 8'h69, 1'b1, g + 11);
        k = 0;
        for (int t = 0; t < 40 && k < 4; t++) begin
            @(negedge CLK);
            if (VID_ACK) begin
                k++;
                VID_ADDR = 9'h030 + 9'(k);
                if (k == 4) VID_REQ = 1'b0;
            end
        end
        chk("vid_burst_count", k, 4);
        @(negedge CLK);
        CPU_REQ = 1'b1;
        CPU_WE = 1'b1;
        CPU_ADDR = 9'h1A5;
        CPU_WDATA = 8'h3C;
        expect_ack(1'b0, 8'h00, 1'b0, cyc + 4);
        @(negedge CLK);
        chk("wr_ws_doe", SRAM_DOE, 1);
        chk("wr_ws_wen", SRAM_WEn, 1);
        chk("wr_ws_cen", SRAM_CEn, 0);
        chk("wr_ws_oen", SRAM_OEn, 1);
        chk("wr_ws_addr", SRAM_ADDR, 9'h1A5);
        chk("wr_ws_dout", SRAM_DOUT, 8'h3C);
        @(negedge CLK);
        chk("wr_wp_wen", SRAM_WEn, 0);
        chk("wr_wp_doe", SRAM_DOE, 1);
        @(negedge CLK);
        chk("wr_wh_wen", SRAM_WEn, 1);
        chk("wr_wh_doe", SRAM_DOE, 1);
        chk("wr_wh_cen", SRAM_CEn, 0);
        @(negedge CLK);
        chk("wr_gap_ack", CPU_ACK, 1);
        chk("wr_gap_doe", SRAM_DOE, 0);
        chk("wr_gap_cen", SRAM_CEn, 1);
        CPU_REQ = 1'b0;
        cpu_op(1'b0, 9'h1A5, 8'h00, 8'h3C, 2);
        FILL_START = 1'b1;
        FILL_DATA = 8'h00;
        @(negedge CLK);
        FILL_START = 1'b0;
        n = 0;
        while (FILL_BUSY && n < 5000) begin
            n++;
            @(negedge CLK);
        end
        chk("fill1_busy_cycles", n, 2048);
        for (int a = 0; a < 512; a++) cpu_op(1'b0, 9'(a), 8'h00, 8'h00, 2);
        @(negedge CLK);
        FILL_START = 1'b1;
        FILL_DATA = 8'hA5;
        @(negedge CLK);
        FILL_START = 1'b0;
        n = 0;
        lat = -1;
        t_req = 0;
        while (FILL_BUSY && n < 5000) begin
            if (n == 1000) begin
                CPU_REQ = 1'b1;
                CPU_WE = 1'b0;
                CPU_ADDR = 9'h000;
                expect_ack(1'b0, 8'hA5, 1'b1, -1);
                t_req = cyc;
            end
            if (CPU_REQ && CPU_ACK) begin
                CPU_REQ = 1'b0;
                lat = cyc - t_req;
            end
            FILL_START = (n == 1200);
            FILL_DATA = (n == 1200) ? 8'h11 : 8'hA5;
            n++;
            @(negedge CLK);
        end
        FILL_START = 1'b0;
        chk("fill2_busy_cycles", n, 2051);
        chk("midfill_latency_ok", lat >= 2 && lat <= 6, 1);
        chk("midfill_req_done", CPU_REQ, 0);
        cpu_op(1'b0, 9'h000, 8'h00, 8'hA5, 2);
        cpu_op(1'b0, 9'h0FF, 8'h00, 8'hA5, 2);
        cpu_op(1'b0, 9'h1FF, 8'h00, 8'hA5, 2);
        repeat (5) @(negedge CLK);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
